timer_ctrl: RTL and testbench

//  Sequencing controller for the microwave countdown timer. Drives load, clear and

---
 rtl/timer_ctrl.sv | 124 ++++++++++++
 tb/tb_timer_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
`timescale 1ns/1ps
// Microwave countdown sequencer: load/clear/count-enable strobes for the BCD digit chain,
// tick prescaler, magnetron gating and completion flag. All outputs registered, one cycle after inputs.
module timer_ctrl #(
  parameter int TICK_DIV    = 100,
  parameter int DONE_CYCLES = 3
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic       keypad_load,
  input  logic       timer_zero,
  output logic       loadn,
  output logic       cnt_clearn,
  output logic       cnt_en,
  output logic       mag_on,
  output logic       done,
  output logic [1:0] state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = ($clog2(DONE_CYCLES + 1) > 0) ? $clog2(DONE_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DONE_LAST  = DW'(DONE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        st_q, st_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          startn_q, stopn_q;
  logic          stop_press, start_press;
  logic          loadn_d, clr_d, en_d;

  // Stop dominates a simultaneous start everywhere.
  assign stop_press  = stopn_q & ~stopn;
  assign start_press = startn_q & ~startn & ~stop_press;

  always_comb begin
    st_d    = st_q;
    presc_d = presc_q;
    dcnt_d  = dcnt_q;
    loadn_d = 1'b1;
    clr_d   = 1'b1;
    en_d    = 1'b0;
    case (st_q)
      IDLE: begin
        if (stop_press) begin
          clr_d = 1'b0;
        end else if (keypad_load) begin
          loadn_d = 1'b0;
        end else if (start_press && door_closed && !timer_zero) begin
          st_d    = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        if (timer_zero) begin
          st_d   = DONE;
          dcnt_d = '0;
        end else if (stop_press || !door_closed) begin
          st_d = PAUSE;
        end else begin
          presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
          en_d    = (presc_q == PRESC_LAST);
        end
      end
      PAUSE: begin
        if (stop_press) begin
          clr_d   = 1'b0;
          presc_d = '0;
          st_d    = IDLE;
        end else if (start_press && door_closed) begin
          st_d = RUN;
        end
      end
      DONE: begin
        if (stop_press || !door_closed || dcnt_q == DONE_LAST) begin
          st_d   = IDLE;
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      st_q       <= IDLE;
      presc_q    <= '0;
      dcnt_q     <= '0;
      startn_q   <= 1'b1;
      stopn_q    <= 1'b1;
      loadn      <= 1'b1;
      cnt_clearn <= 1'b1;
      cnt_en     <= 1'b0;
      mag_on     <= 1'b0;
      done       <= 1'b0;
    end else begin
      st_q       <= st_d;
      presc_q    <= presc_d;
      dcnt_q     <= dcnt_d;
      startn_q   <= startn;
      stopn_q    <= stopn;
      loadn      <= loadn_d;
      cnt_clearn <= clr_d;
      cnt_en     <= en_d;
      mag_on     <= (st_d == RUN);
      done       <= (st_d == DONE);
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_timer_ctrl.sv
`timescale 1ns/1ps
// Bench for timer_ctrl: directed vector table, hand-written corner sequences and random
// stimulus checked against a cycle-level behavioural model.
module tb_timer_ctrl;
  localparam int TD = 4;
  localparam int DC = 3;

  logic clock = 1'b0;
  logic clearn = 1'b1;
  logic startn = 1'b1, stopn = 1'b1, door_closed = 1'b1, keypad_load = 1'b0, timer_zero = 1'b0;
  logic loadn, cnt_clearn, cnt_en, mag_on, done;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  timer_ctrl #(.TICK_DIV(TD), .DONE_CYCLES(DC)) dut (
    .clock(clock), .clearn(clearn), .startn(startn), .stopn(stopn),
    .door_closed(door_closed), .keypad_load(keypad_load), .timer_zero(timer_zero),
    .loadn(loadn), .cnt_clearn(cnt_clearn), .cnt_en(cnt_en), .mag_on(mag_on),
    .done(done), .state(state)
  );

  // Vector layout: {state[1:0], loadn, cnt_clearn, cnt_en, mag_on, done}
  localparam logic [6:0] V_IDLE  = 7'b0011000;
  localparam logic [6:0] V_LOAD  = 7'b0001000;
  localparam logic [6:0] V_CLR   = 7'b0010000;
  localparam logic [6:0] V_RUN   = 7'b0111010;
  localparam logic [6:0] V_RUNE  = 7'b0111110;
  localparam logic [6:0] V_PAUSE = 7'b1011000;
  localparam logic [6:0] V_DONE  = 7'b1111001;

  function automatic logic [6:0] dut_vec();
    return {state, loadn, cnt_clearn, cnt_en, mag_on, done};
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
  endtask

  // Model: mode 0..3, elapsed = RUN cycles that were followed by RUN since the last start.
  int         m_mode, m_elapsed, m_dleft;
  bit         m_ps, m_pt;
  logic [6:0] m_exp;

  task automatic model_reset();
    m_mode = 0; m_elapsed = 0; m_dleft = 0; m_ps = 1'b1; m_pt = 1'b1; m_exp = V_IDLE;
  endtask

  task automatic model_step();
    bit sp, tp, l, c, e;
    int nm;
    tp = m_pt && !stopn;
    sp = m_ps && !startn && !tp;
    l = 1'b1; c = 1'b1; e = 1'b0; nm = m_mode;
    case (m_mode)
      0: if (tp) c = 1'b0;
         else if (keypad_load) l = 1'b0;
         else if (sp && door_closed && !timer_zero) begin nm = 1; m_elapsed = 0; end
      1: if (timer_zero) begin nm = 3; m_dleft = DC; end
         else if (tp || !door_closed) nm = 2;
         else begin m_elapsed++; e = (m_elapsed % TD == 0); end
      2: if (tp) begin c = 1'b0; nm = 0; end
         else if (sp && door_closed) nm = 1;
      default: if (tp || !door_closed) nm = 0;
         else begin m_dleft--; if (m_dleft == 0) nm = 0; end
    endcase
    m_mode = nm;
    m_ps = startn; m_pt = stopn;
    m_exp = {2'(nm), l, c, e, nm == 1, nm == 3};
  endtask

  task automatic tick(input string name);
    model_step();
    @(posedge clock);
    @(negedge clock);
    check(name, dut_vec(), m_exp);
  endtask

  typedef struct {
    logic sn, tn, dr, kl, tz;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[22];

  function automatic vec_t mk(input logic sn, tn, dr, kl, tz, input logic [6:0] exp);
    vec_t v;
    v.sn = sn; v.tn = tn; v.dr = dr; v.kl = kl; v.tz = tz; v.exp = exp;
    return v;
  endfunction

  initial begin
    bit seen;
    tbl[0]  = mk(1,1,1,0,0, V_IDLE);
    tbl[1]  = mk(1,1,1,1,0, V_LOAD);
    tbl[2]  = mk(1,1,1,0,0, V_IDLE);
    tbl[3]  = mk(0,1,1,0,0, V_RUN);
    tbl[4]  = mk(0,1,1,0,0, V_RUN);
    tbl[5]  = mk(1,1,1,0,0, V_RUN);
    tbl[6]  = mk(1,1,1,0,0, V_RUN);
    tbl[7]  = mk(1,1,1,0,0, V_RUNE);
    tbl[8]  = mk(1,1,1,0,0, V_RUN);
    tbl[9]  = mk(1,1,1,0,0, V_RUN);
    tbl[10] = mk(1,1,1,0,0, V_RUN);
    tbl[11] = mk(1,1,1,0,0, V_RUNE);
    tbl[12] = mk(1,1,1,0,1, V_DONE);
    tbl[13] = mk(1,1,1,0,1, V_DONE);
    tbl[14] = mk(1,1,1,0,0, V_DONE);
    tbl[15] = mk(1,1,1,0,0, V_IDLE);
    tbl[16] = mk(0,0,1,0,0, V_CLR);
    tbl[17] = mk(1,1,1,0,0, V_IDLE);
    tbl[18] = mk(0,1,0,0,0, V_IDLE);
    tbl[19] = mk(1,1,1,0,1, V_IDLE);
    tbl[20] = mk(0,1,1,0,1, V_IDLE);
    tbl[21] = mk(1,1,1,0,0, V_IDLE);

    // Asynchronous reset mid-cycle, then idle with buttons released.
    #2 clearn = 1'b0;
    #1 check("reset_async", dut_vec(), V_IDLE);
    model_reset();
    @(negedge clock);
    clearn = 1'b1;
    for (int i = 0; i < 3; i++) tick("reset_idle");

    for (int i = 0; i < 22; i++) begin
      startn = tbl[i].sn; stopn = tbl[i].tn; door_closed = tbl[i].dr;
      keypad_load = tbl[i].kl; timer_zero = tbl[i].tz;
      tick("vec_model");
      check($sformatf("vec_%0d", i), dut_vec(), tbl[i].exp);
    end

    // Door interlock with held prescaler, then cancel from PAUSE.
    startn = 1'b0; tick("il_start");
    startn = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick("il_wait");
      seen = cnt_en;
    end
    check("il_first_en", {6'b0, seen}, 7'd1);
    tick("il_a"); tick("il_b");
    door_closed = 1'b0; tick("il_open");
    check("il_pause", dut_vec(), V_PAUSE);
    tick("il_open2");
    check("il_pause_hold", dut_vec(), V_PAUSE);
    startn = 1'b0; tick("il_blocked");
    check("il_start_door_open", dut_vec(), V_PAUSE);
    startn = 1'b1; tick("il_rel");
    door_closed = 1'b1; startn = 1'b0; tick("il_resume");
    check("il_resume", dut_vec(), V_RUN);
    startn = 1'b1; tick("il_r1");
    check("il_r1", dut_vec(), V_RUN);
    tick("il_r2");
    check("il_resume_en", dut_vec(), V_RUNE);
    door_closed = 1'b0; tick("il_open3");
    door_closed = 1'b1; stopn = 1'b0; tick("cancel");
    check("pause_cancel", dut_vec(), V_CLR);
    stopn = 1'b1; tick("cancel_rel");
    check("cancel_rel", dut_vec(), V_IDLE);

    // Reset while the magnetron is on.
    startn = 1'b0; tick("rr_start");
    startn = 1'b1; tick("rr_run");
    check("rr_mag_on", {6'b0, mag_on}, 7'd1);
    #2 clearn = 1'b0;
    #1 check("reset_mid_run", dut_vec(), V_IDLE);
    model_reset();
    @(negedge clock);
    clearn = 1'b1;
    tick("rr_after");

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      startn      = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
      stopn       = ($urandom_range(0, 19) < 2) ? 1'b0 : 1'b1;
      door_closed = ($urandom_range(0, 19) < 17) ? 1'b1 : 1'b0;
      keypad_load = ($urandom_range(0, 9) == 0);
      timer_zero  = ($urandom_range(0, 19) < 2);
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
